mips_ifetch_queue: RTL and testbench

MIPS_IFETCH_QUEUE -- requirements
Module: mips_ifetch_queue

---
 rtl/mips_ifetch_queue.sv | 169 ++++++++++++++++
 tb/tb_mips_ifetch_queue.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_ifetch_queue.sv
// Instruction prefetch queue: one outstanding memory read, DEPTH-entry {ir, npc} FIFO.
// Define MIPS_IFQ_HALT_DETECT_EN to stop fetching after a pushed HLT word (opcode 6'b111111).
module mips_ifetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [31:0]       out_ir,
  output logic [31:0]       out_npc,
  input  logic              out_ready,
  output logic              halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

`ifdef MIPS_IFQ_HALT_DETECT_EN
  typedef enum logic [1:0] {StFetch, StWait, StDrain, StHalt} state_e;
`else
  typedef enum logic [1:0] {StFetch, StWait, StDrain} state_e;
`endif

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CntW-1:0]   count_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [31:0]       ir_mem  [DEPTH];
  logic [ADDR_W-1:0] npc_mem [DEPTH];

  logic              pop;
  logic              ack_push;
  logic [ADDR_W-1:0] pc_inc;
  logic [CntW-1:0]   count_after;

  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready && !redirect;
  // Data returned for a flushed request (DRAIN, or ack coincident with redirect) is dropped.
  assign ack_push    = (state_q == StWait) && mem_ack && !redirect;
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign count_after = count_q + CntW'(ack_push) - CntW'(pop);

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign out_ir   = out_valid ? ir_mem[rd_ptr_q] : '0;
  assign out_npc  = out_valid ? 32'(npc_mem[rd_ptr_q]) : '0;

`ifdef MIPS_IFQ_HALT_DETECT_EN
  logic halted_q;
  logic is_hlt;
  assign is_hlt = (mem_rdata[31:26] == 6'b111111);
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
`ifdef MIPS_IFQ_HALT_DETECT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFetch: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end else if (count_q < DepthCnt) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (redirect) begin
            pc_q <= redirect_pc;
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              state_q   <= StFetch;
            end else begin
              state_q <= StDrain;
            end
          end else if (mem_ack) begin
            pc_q <= pc_inc;
`ifdef MIPS_IFQ_HALT_DETECT_EN
            if (is_hlt) begin
              mem_req_q <= 1'b0;
              halted_q  <= 1'b1;
              state_q   <= StHalt;
            end else
`endif
            if (count_after < DepthCnt) begin
              // Back-to-back request: stay in WAIT with the next address.
              mem_req_q  <= 1'b1;
              mem_addr_q <= pc_inc;
            end else begin
              mem_req_q <= 1'b0;
              state_q   <= StFetch;
            end
          end
        end
        StDrain: begin
          if (redirect) begin
            pc_q <= redirect_pc;
          end
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= StFetch;
          end
        end
`ifdef MIPS_IFQ_HALT_DETECT_EN
        StHalt: begin
          if (redirect) begin
            pc_q     <= redirect_pc;
            halted_q <= 1'b0;
            state_q  <= StFetch;
          end
        end
`endif
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= StFetch;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (ack_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_after;
    end
  end

  always_ff @(posedge clk) begin
    if (ack_push) begin
      ir_mem[wr_ptr_q]  <= mem_rdata;
      npc_mem[wr_ptr_q] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_mips_ifetch_queue.sv
// Bench for mips_ifetch_queue: directed scenarios plus randomized traffic checked every
// cycle against a queue-based model of the prefetch stream.
module tb_mips_ifetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned MEMSZ = 1 << AW;
`ifdef MIPS_IFQ_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic [31:0]   out_ir;
  logic [31:0]   out_npc;
  logic          out_ready;
  logic          halted;

  mips_ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ir     (out_ir),
    .out_npc    (out_npc),
    .out_ready  (out_ready),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Instruction memory responder
  logic [31:0] mem_arr [MEMSZ];
  bit hold_ack = 1'b0;
  bit rand_lat = 1'b0;
  int cur_lat  = 0;
  int wcnt     = 0;
  int ack_cnt  = 0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    #2;
    if (!rst_n || !mem_req || hold_ack) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      wcnt      = 0;
    end else if (wcnt >= cur_lat) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_arr[mem_addr];
      wcnt      = 0;
      ack_cnt++;
      cur_lat   = rand_lat ? int'($urandom_range(0, 3)) : 0;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      wcnt++;
    end
  end

  // Reference model: the stream of entries the queue must present, and the next fetch address
  typedef struct {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_pc       = 0;
  bit          m_halted   = 1'b0;
  bit          draining   = 1'b0;
  logic [AW-1:0] drain_addr = '0;
  bit          pending    = 1'b0;
  int          idle       = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("rst_mem_req", mem_req, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_ir", out_ir, 0);
      check_eq("rst_out_npc", out_npc, 0);
      check_eq("rst_halted", halted, 0);
      mq.delete();
      m_pc     = 0;
      m_halted = 1'b0;
      draining = 1'b0;
      pending  = 1'b0;
      idle     = 0;
    end else begin
      check_eq("out_valid", out_valid, mq.size() != 0);
      check_eq("out_ir", out_ir, (mq.size() != 0) ? mq[0].ir : 32'h0);
      check_eq("out_npc", out_npc, (mq.size() != 0) ? mq[0].npc : 32'h0);
      check_eq("halted", halted, m_halted);
      if (draining) begin
        check_eq("drain_req_held", mem_req, 1);
        check_eq("drain_addr", mem_addr, drain_addr);
      end else if (mem_req) begin
        check_eq("req_addr", mem_addr, m_pc);
        check_eq("req_room", mq.size() < DEPTH, 1);
        check_eq("req_in_halt", m_halted, 0);
      end
      if (pending) check_eq("req_dropped", mem_req, 1);
      if (!mem_req && !m_halted && mq.size() < DEPTH && !redirect) idle++;
      else idle = 0;
      check_eq("fetch_stall", idle <= 2, 1);
      pending = mem_req && !mem_ack;

      // Apply this cycle's events, effective at the coming edge
      if (redirect) begin
        mq.delete();
        m_pc     = redirect_pc;
        m_halted = 1'b0;
        if (mem_req && !mem_ack) begin
          if (!draining) drain_addr = mem_addr;
          draining = 1'b1;
        end else begin
          draining = 1'b0;
        end
      end else begin
        if (out_valid && out_ready && mq.size() != 0) void'(mq.pop_front());
        if (mem_ack) begin
          if (draining) begin
            draining = 1'b0;
          end else begin
            ent_t e;
            m_pc  = (m_pc + 1) % MEMSZ;
            e.ir  = mem_rdata;
            e.npc = m_pc;
            mq.push_back(e);
            if (HaltEn && mem_rdata[31:26] == 6'b111111) m_halted = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit ready);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = ready;
    tick();
    tick();
    rst_n   = 1'b1;
    ack_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic [31:0] saved;
    logic [31:0] exp_ir [3];

    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b0;
    for (int i = 0; i < int'(MEMSZ); i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31] = 1'b0;
      mem_arr[i] = w;
    end

    // Reset values and first request, then streaming with 1-cycle memory
    tick();
    tick();
    check_eq("reset_mem_req", mem_req, 0);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_halted", halted, 0);
    out_ready = 1'b1;
    rst_n     = 1'b1;
    tick();
    check_eq("first_req", mem_req, 1);
    check_eq("first_addr", mem_addr, 0);
    got = 0;
    for (int c = 0; c < 30 && got < 3; c++) begin
      if (out_valid) begin
        check_eq("stream_ir", out_ir, mem_arr[got]);
        check_eq("stream_npc", out_npc, got + 1);
        got++;
      end
      tick();
    end
    check_eq("stream_count", got, 3);

    // Backpressure: exactly DEPTH acks, then one pop reopens fetch at addr 4
    do_reset(1'b0);
    repeat (12) tick();
    check_eq("full_acks", ack_cnt, 4);
    check_eq("full_req", mem_req, 0);
    check_eq("full_head", out_ir, mem_arr[0]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check_eq("refill_req", mem_req, 1);
    check_eq("refill_addr", mem_addr, 4);
    check_eq("refill_head_npc", out_npc, 2);

    // Redirect while waiting; ack arrives later and is discarded
    hold_ack = 1'b1;
    do_reset(1'b1);
    tick();
    check_eq("wait_req", mem_req, 1);
    redirect    = 1'b1;
    redirect_pc = AW'(20);
    tick();
    redirect = 1'b0;
    check_eq("drain_req", mem_req, 1);
    check_eq("drain_old_addr", mem_addr, 0);
    tick();
    tick();
    hold_ack = 1'b0;
    tick();
    check_eq("post_drain_req", mem_req, 0);
    check_eq("post_drain_valid", out_valid, 0);
    tick();
    check_eq("redir_req", mem_req, 1);
    check_eq("redir_addr", mem_addr, 20);
    tick();
    check_eq("redir_valid", out_valid, 1);
    check_eq("redir_npc", out_npc, 21);
    check_eq("redir_ir", out_ir, mem_arr[20]);

    // Redirect coincident with ack, two entries queued
    do_reset(1'b0);
    tick();
    tick();
    tick();
    check_eq("pre_flush_valid", out_valid, 1);
    check_eq("pre_flush_npc", out_npc, 1);
    redirect    = 1'b1;
    redirect_pc = AW'(100);
    tick();
    redirect = 1'b0;
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_req", mem_req, 0);
    tick();
    check_eq("flush_next_req", mem_req, 1);
    check_eq("flush_next_addr", mem_addr, 100);

    // PC wrap at 1023
    do_reset(1'b1);
    redirect    = 1'b1;
    redirect_pc = AW'(1023);
    tick();
    redirect = 1'b0;
    check_eq("wrap_idle", mem_req, 0);
    tick();
    check_eq("wrap_addr_hi", mem_addr, 1023);
    tick();
    check_eq("wrap_npc0", out_npc, 0);
    check_eq("wrap_ir", out_ir, mem_arr[1023]);
    check_eq("wrap_addr0", mem_addr, 0);
    tick();
    check_eq("wrap_npc1", out_npc, 1);
    check_eq("wrap_ir0", out_ir, mem_arr[0]);

`ifdef MIPS_IFQ_HALT_DETECT_EN
    // HLT at address 2 stops fetching; queued entries still drain
    saved      = mem_arr[2];
    mem_arr[2] = 32'hFC00_0000;
    exp_ir[0]  = mem_arr[0];
    exp_ir[1]  = mem_arr[1];
    exp_ir[2]  = 32'hFC00_0000;
    do_reset(1'b0);
    repeat (4) tick();
    check_eq("hlt_halted", halted, 1);
    check_eq("hlt_no_req", mem_req, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("hlt_quiet", mem_req, 0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_eq("hlt_drain_ir", out_ir, exp_ir[k]);
      check_eq("hlt_drain_npc", out_npc, k + 1);
      tick();
    end
    out_ready = 1'b0;
    check_eq("hlt_empty", out_valid, 0);
    check_eq("hlt_still", halted, 1);
    redirect    = 1'b1;
    redirect_pc = AW'(5);
    tick();
    redirect = 1'b0;
    check_eq("hlt_exit", halted, 0);
    tick();
    check_eq("hlt_restart_req", mem_req, 1);
    check_eq("hlt_restart_addr", mem_addr, 5);
    mem_arr[2] = saved;
`else
    saved     = '0;
    exp_ir[0] = saved;
`endif

    // Randomized traffic, HLT words sprinkled (plain words when detection is off)
    for (int i = 0; i < 40; i++) begin
      mem_arr[$urandom_range(0, MEMSZ - 1)] = {6'b111111, 26'($urandom)};
    end
    rand_lat = 1'b1;
    do_reset(1'b1);
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0:       out_ready = ($urandom_range(0, 9) < 9);
        1:       out_ready = ($urandom_range(0, 9) < 3);
        default: out_ready = ($urandom_range(0, 9) == 0);
      endcase
      redirect = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = AW'(MEMSZ - 1);
        1:       redirect_pc = AW'(MEMSZ - 2);
        default: redirect_pc = AW'($urandom);
      endcase
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    redirect  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
